pc_return_stack: RTL

//  Return-address stack: the producer of FROM_STACK, the PC source at PC_MUX_SEL=1.
//  On CALL, the control unit pushes the return address (PC_COUNT+1).
//  On RET, the top entry drives FROM_STACK in the same cycle the PC loads it (PC_LD=1).
//  The pop happens on that same clock edge.

---
 rtl/rat_pkg.sv | 45 ++++
 rtl/pc_return_stack_if.sv | 30 +++
 rtl/stack_ram.sv | 22 ++
 rtl/pc_return_stack.sv | 97 +++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared definitions for the return-address stack and the PC source mux.
package rat_pkg;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    SEL_IMMED  = 2'd0,
    SEL_STACK  = 2'd1,
    SEL_VECTOR = 2'd2
  } pc_mux_sel_e;

  localparam logic [PC_W-1:0] VECTOR_ADDR = 10'h3FF;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } stack_op_e;

  // A simultaneous push/pop on an empty stack degrades to a plain push.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty);
    stack_op_e op;
    op = OP_NONE;
    if (push && pop)  op = empty ? OP_PUSH : OP_REPL;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
    return op;
  endfunction

  function automatic logic [PC_W-1:0] pc_mux_next(input logic [1:0] sel,
                                                  input logic [PC_W-1:0] immed,
                                                  input logic [PC_W-1:0] from_stack);
    logic [PC_W-1:0] nxt;
    case (sel)
      SEL_IMMED:  nxt = immed;
      SEL_STACK:  nxt = from_stack;
      SEL_VECTOR: nxt = VECTOR_ADDR;
      default:    nxt = '0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pc_return_stack_if.sv
// Control-unit side of the return-address stack: op requests in, stack status out.
interface pc_return_stack_if #(
  parameter int PC_W  = rat_pkg::PC_W,
  parameter int DEPTH = 32
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic            push;
  logic            pop;
  logic [PC_W-1:0] push_data;
  logic            sp_ld;
  logic [SPW-1:0]  sp_in;
  logic [PC_W-1:0] from_stack;
  logic [SPW-1:0]  sp;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;

  modport master (
    output push, pop, push_data, sp_ld, sp_in,
    input  from_stack, sp, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, sp_ld, sp_in,
    output from_stack, sp, empty, full, overflow, underflow
  );

endinterface

// File: rtl/stack_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int WIDTH = rat_pkg::PC_W,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_return_stack.sv
// Return-address stack: SP register, op decode, sticky flags and the
// zero-latency top-of-stack read path that feeds the PC mux.
module pc_return_stack #(
  parameter int PC_W  = rat_pkg::PC_W,
  parameter int DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  pc_return_stack_if.slave stk
);
  import rat_pkg::*;

  localparam int             AW     = $clog2(DEPTH);
  localparam int             SPW    = AW + 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [SPW-1:0]  sp_q;
  logic            ovf_q;
  logic            unf_q;
  logic            empty;
  logic            full;
  stack_op_e       op;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   top_addr;
  logic [PC_W-1:0] rd_data;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_MAX);
  assign op       = decode_op(stk.push, stk.pop, empty);
  assign top_addr = sp_q[AW-1:0] - AW'(1);

  // Reset and SP loads suppress the write so storage stays untouched.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sp_q[AW-1:0];
    if (!rst && !stk.sp_ld) begin
      case (op)
        OP_PUSH: wr_en = !full;
        OP_REPL: begin
          wr_en   = 1'b1;
          wr_addr = top_addr;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (stk.sp_ld) begin
      if (stk.sp_in > SP_MAX) begin
        sp_q  <= SP_MAX;
        ovf_q <= 1'b1;
      end else begin
        sp_q <= stk.sp_in;
      end
    end else begin
      case (op)
        OP_PUSH: begin
          if (full) ovf_q <= 1'b1;
          else      sp_q  <= sp_q + SPW'(1);
          // Only reachable with pop set when the stack was empty.
          if (stk.pop) unf_q <= 1'b1;
        end
        OP_POP: begin
          if (empty) unf_q <= 1'b1;
          else       sp_q  <= sp_q - SPW'(1);
        end
        default: sp_q <= sp_q;
      endcase
    end
  end

  stack_ram #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (stk.push_data),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  assign stk.from_stack = empty ? '0 : rd_data;
  assign stk.sp         = sp_q;
  assign stk.empty      = empty;
  assign stk.full       = full;
  assign stk.overflow   = ovf_q;
  assign stk.underflow  = unf_q;

endmodule
